store_monitor: RTL and testbench

- Synthesizable receiving end of the processor's data-store bus (MemWrite, DataAdr, WriteData) at the top level.
- Logs every store into a small FIFO that test logic drains.
- Decides test outcome: the store to the completion address either matches the expected value (pass) or does not (fail); otherwise a watchdog declares timeout.
- Instantiated beside the top-level core so benches and FPGA builds share one pass/fail mechanism.

---
 rtl/store_monitor.sv | 147 ++++++++++++++
 tb/tb_store_monitor.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/store_monitor.sv
// rtl/store_monitor.sv - data-store bus monitor: store log FIFO, pass/fail decision and watchdog
module store_monitor #(
    parameter int          DEPTH       = 8,
    parameter logic [31:0] DONE_ADR    = 32'd100,
    parameter logic [31:0] EXPECT_DATA = 32'd7,
    parameter int          TIMEOUT     = 1000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     MemWrite,
    input  logic [31:0]              DataAdr,
    input  logic [31:0]              WriteData,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output logic [31:0]              rd_adr,
    output logic [31:0]              rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     done,
    output logic                     pass,
    output logic                     fail,
    output logic                     timeout,
    output logic [31:0]              cycles
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [31:0]   TMO_LAST = 32'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [31:0]     r_mem_adr  [DEPTH];
    logic [31:0]     r_mem_data [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_next;
    logic            r_overflow;
    logic            r_done;
    logic            r_pass;
    logic            r_fail;
    logic            r_timeout;
    logic [31:0]     r_cycles;

    logic            w_run;
    logic            w_push_req;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic            w_done_store;

    assign w_run        = (r_state == ST_RUN);
    assign w_push_req   = MemWrite && w_run;
    assign w_full       = (r_count == FULL_CNT);
    assign w_pop        = rd_en && (r_count != '0);
    // A pop on the same edge frees the slot the full-FIFO push lands in.
    assign w_push       = w_push_req && (!w_full || w_pop);
    assign w_drop       = w_push_req && w_full && !w_pop;
    assign w_done_store = w_push_req && (DataAdr == DONE_ADR);

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CW'(1);
            2'b01:   w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                // Completion store outranks watchdog expiry on the same edge.
                if (w_done_store) begin
                    w_state_next = (WriteData == EXPECT_DATA) ? ST_PASS : ST_FAIL;
                end else if (r_cycles == TMO_LAST) begin
                    w_state_next = ST_TIMEOUT;
                end
            end
            default: w_state_next = r_state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_RUN;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_fail     <= 1'b0;
            r_timeout  <= 1'b0;
            r_cycles   <= '0;
        end else begin
            r_state   <= w_state_next;
            r_count   <= w_count_next;
            r_done    <= (w_state_next != ST_RUN);
            r_pass    <= (w_state_next == ST_PASS);
            r_fail    <= (w_state_next == ST_FAIL);
            r_timeout <= (w_state_next == ST_TIMEOUT);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_run) begin
                r_cycles <= r_cycles + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_adr[r_wr_ptr]  <= DataAdr;
            r_mem_data[r_wr_ptr] <= WriteData;
        end
    end

    assign rd_valid = (r_count != '0);
    assign rd_adr   = rd_valid ? r_mem_adr[r_rd_ptr]  : 32'd0;
    assign rd_data  = rd_valid ? r_mem_data[r_rd_ptr] : 32'd0;
    assign count    = r_count;
    assign overflow = r_overflow;
    assign done     = r_done;
    assign pass     = r_pass;
    assign fail     = r_fail;
    assign timeout  = r_timeout;
    assign cycles   = r_cycles;

endmodule

// File: tb/tb_store_monitor.sv
// tb/tb_store_monitor.sv - directed self-checking bench for store_monitor
module tb_store_monitor;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        rd_en;
    logic        rd_valid;
    logic [31:0] rd_adr;
    logic [31:0] rd_data;
    logic [3:0]  count;
    logic        overflow;
    logic        done;
    logic        pass;
    logic        fail;
    logic        timeout;
    logic [31:0] cycles;

    int n_tests = 0;
    int n_fails = 0;

    store_monitor #(
        .DEPTH(8), .DONE_ADR(32'd100), .EXPECT_DATA(32'd7), .TIMEOUT(1000)
    ) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
        .WriteData(WriteData), .rd_en(rd_en), .rd_valid(rd_valid),
        .rd_adr(rd_adr), .rd_data(rd_data), .count(count), .overflow(overflow),
        .done(done), .pass(pass), .fail(fail), .timeout(timeout), .cycles(cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        MemWrite = 1'b0;
        rd_en    = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic store(input logic [31:0] adr, input logic [31:0] data);
        MemWrite  = 1'b1;
        DataAdr   = adr;
        WriteData = data;
        tick();
    endtask

    initial begin
        reset = 1'b1; MemWrite = 1'b0; DataAdr = '0; WriteData = '0; rd_en = 1'b0;
        #2;

        // reset state
        do_reset();
        check("rst_count", 32'(count), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_adr", rd_adr, 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_flags", {27'd0, overflow, done, pass, fail, timeout}, 32'd0);
        check("rst_cycles", cycles, 32'd0);

        // watchdog
        repeat (999) tick();
        check("wd_cycles_999", cycles, 32'd999);
        check("wd_not_yet", 32'(timeout), 32'd0);
        tick();
        check("wd_flags", {28'd0, done, pass, fail, timeout}, 32'b1001);
        check("wd_cycles_1000", cycles, 32'd1000);
        tick();
        check("wd_cycles_frozen", cycles, 32'd1000);

        // pass sequence and in-order drain
        do_reset();
        store(32'h10, 32'hA);
        store(32'h14, 32'hB);
        check("pass_not_early", 32'(done), 32'd0);
        store(32'd100, 32'd7);
        MemWrite = 1'b0;
        check("pass_flags", {28'd0, done, pass, fail, timeout}, 32'b1100);
        check("pass_count", 32'(count), 32'd3);
        check("pop0_adr", rd_adr, 32'h10);
        check("pop0_data", rd_data, 32'hA);
        rd_en = 1'b1;
        tick();
        check("pop1_adr", rd_adr, 32'h14);
        check("pop1_data", rd_data, 32'hB);
        tick();
        check("pop2_adr", rd_adr, 32'd100);
        check("pop2_data", rd_data, 32'd7);
        tick();
        check("drained_valid", 32'(rd_valid), 32'd0);
        check("drained_adr", rd_adr, 32'd0);
        tick();
        check("empty_pop_ignored", 32'(count), 32'd0);
        rd_en = 1'b0;

        // fail sequence, stores ignored afterwards
        do_reset();
        store(32'd100, 32'd8);
        MemWrite = 1'b0;
        check("fail_flags", {28'd0, done, pass, fail, timeout}, 32'b1010);
        check("fail_count", 32'(count), 32'd1);
        store(32'h20, 32'd1);
        MemWrite = 1'b0;
        check("fail_ignore_store", 32'(count), 32'd1);
        check("fail_head", rd_adr, 32'd100);

        // overflow and full push+pop
        do_reset();
        for (int i = 0; i < 9; i++) store(32'h100 + i, 32'h1000 + i);
        MemWrite = 1'b0;
        check("ovf_count", 32'(count), 32'd8);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_head_adr", rd_adr, 32'h100);
        check("ovf_head_data", rd_data, 32'h1000);
        rd_en = 1'b1;
        store(32'h109, 32'h1009);
        MemWrite = 1'b0;
        rd_en    = 1'b0;
        check("full_pushpop_count", 32'(count), 32'd8);
        check("ovf_sticky", 32'(overflow), 32'd1);
        rd_en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            int idx;
            idx = (k < 7) ? k + 1 : 9;
            check($sformatf("drain%0d_adr", k), rd_adr, 32'h100 + idx);
            check($sformatf("drain%0d_data", k), rd_data, 32'h1000 + idx);
            tick();
        end
        rd_en = 1'b0;
        check("drain_done", 32'(count), 32'd0);

        // completion beats watchdog
        do_reset();
        repeat (999) tick();
        check("race_cycles", cycles, 32'd999);
        store(32'd100, 32'd7);
        MemWrite = 1'b0;
        check("race_flags", {28'd0, done, pass, fail, timeout}, 32'b1100);

        // mid-run reset
        do_reset();
        store(32'h30, 32'd1);
        store(32'h34, 32'd2);
        store(32'h38, 32'd3);
        MemWrite = 1'b0;
        check("mid_pre_count", 32'(count), 32'd3);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("mid_count", 32'(count), 32'd0);
        check("mid_valid", 32'(rd_valid), 32'd0);
        check("mid_overflow", 32'(overflow), 32'd0);
        check("mid_cycles", cycles, 32'd0);
        check("mid_done", 32'(done), 32'd0);
        store(32'h40, 32'd5);
        MemWrite = 1'b0;
        check("mid_resume_count", 32'(count), 32'd1);
        check("mid_resume_adr", rd_adr, 32'h40);
        check("mid_resume_data", rd_data, 32'd5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
